// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer
// Runs AES-CTR sessions for up to NREQ requesters that share one AES core.
// A round-robin arbiter picks the next requester. The sequencer draws one
// fresh nonce for the session and issues the counter blocks
// {nonce, block_index} one at a time. When the last block comes back, it
// pulses done to the requester that owns the session.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   req          per-requester session request (level, held until done)
//   req_len      per-requester block count, requester i at [i*LEN_W +: LEN_W]
//   gnt          one-hot grant, high for the whole session
//   done         one-cycle completion pulse to the owner
//   nonce_ready  one-cycle pulse to the nonce generator's ready input
//   nonce_data   nonce generator output
//   aes_start    one-cycle pulse, aes_block valid
//   aes_block    {session nonce, block counter}
//   aes_done     one-cycle pulse from the AES core, block finished
//   last_blk     high with aes_start on the final block of the session
//   busy         high in any state other than IDLE
module aes_ctr_sequencer #(
  parameter int          NREQ     = 2,
  parameter int          LEN_W    = 16,
  parameter logic [63:0] CTR_INIT = 64'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  nonce_ready,
  input  logic [63:0]           nonce_data,
  output logic                  aes_start,
  output logic [127:0]          aes_block,
  input  logic                  aes_done,
  output logic                  last_blk,
  output logic                  busy
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, NREQ_S, NCAP, ISSUE, WAIT, FIN} state_t;

  state_t           state, state_nxt;
  logic [OW-1:0]    owner, rr, pick_idx;
  logic             pick_valid;
  logic [LEN_W-1:0] pick_len, len_q, remaining;
  logic [63:0]      nonce_q, cnt;
  logic [NREQ-1:0]  owner_oh;

  // Round-robin search: first set request at or above rr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && req[(int'(rr) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'((int'(rr) + k) % NREQ);
      end
    end
  end

  assign pick_len = req_len[pick_idx*LEN_W +: LEN_W];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A zero-length session skips the nonce draw and the
  // AES traffic, and goes straight to the completion pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = (pick_len == '0) ? FIN : NREQ_S;
      NREQ_S:  state_nxt = NCAP;
      NCAP:    state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (aes_done) state_nxt = (remaining == LEN_W'(1)) ? FIN : ISSUE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Session datapath. The owner and its length are captured only at grant,
  // so later changes on req/req_len cannot disturb a running session. The
  // nonce is captured in NCAP because the generator advances on the edge
  // that ends NREQ_S.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= '0;
      rr        <= '0;
      len_q     <= '0;
      remaining <= '0;
      nonce_q   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            len_q <= pick_len;
          end
        end
        NCAP: begin
          nonce_q   <= nonce_data;
          cnt       <= CTR_INIT;
          remaining <= len_q;
        end
        WAIT: begin
          if (aes_done) begin
            cnt       <= cnt + 64'd1;
            remaining <= remaining - LEN_W'(1);
          end
        end
        FIN: begin
          rr <= (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state, so an asynchronous reset clears
  // them immediately.
  assign owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign busy        = (state != IDLE);
  assign gnt         = busy ? owner_oh : '0;
  assign done        = (state == FIN) ? owner_oh : '0;
  assign nonce_ready = (state == NREQ_S);
  assign aes_start   = (state == ISSUE);
  assign last_blk    = aes_start && (remaining == LEN_W'(1));
  assign aes_block   = {nonce_q, cnt};

endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
Sequences AES-CTR sessions. Round-robin arbitrates up to NREQ requesters for the single AES core. Draws one fresh 64-bit nonce per session from the nonce LFSR generator. Issues counter blocks {nonce, block_index} to the AES core one at a time, then signals completion to the owning requester.

Parameters:
NREQ, 2, number of requesters (2..4)
LEN_W, 16, width of per-requester block-count field
CTR_INIT, 0, 64-bit initial block-counter value for each session

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester session request, level, held until done
req_len  in  NREQ*LEN_W  per-requester block count, requester i at bits [i*LEN_W +: LEN_W]
gnt  out  NREQ  one-hot grant, high for the whole session
done  out  NREQ  one-cycle completion pulse to the owner
nonce_ready  out  1  one-cycle pulse to the nonce generator's ready input
nonce_data  in  64  nonce generator outData
aes_start  out  1  one-cycle pulse, aes_block valid
aes_block  out  128  {session nonce[63:0], counter[63:0]}
aes_done  in  1  one-cycle pulse from the AES core, block finished
last_blk  out  1  high with aes_start when the issued block is the final one of the session
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; gnt, done, nonce_ready, aes_start, last_blk and busy = 0.
  - aes_block=0; rr pointer=0.
  - Reset mid-session abandons the session silently: no done pulse, and an in-flight aes_done is ignored.
- States: IDLE, NREQ_S, NCAP, ISSUE, WAIT, FIN.
- IDLE:
  - If any req bit is set, grant the first set bit searching from the rr pointer upward, with wrap.
  - gnt registered next cycle. Latch the owner id and its req_len into len_q. Go to NREQ_S.
  - If the latched len is 0, go directly to FIN instead. No nonce is drawn and no AES block is issued.
- NREQ_S: nonce_ready=1 for exactly one cycle; go to NCAP.
  - The generator updates outData on the same edge, so it is stable one cycle later.
- NCAP: sample nonce_data into nonce_q; cnt=CTR_INIT; remaining=len_q; go to ISSUE.
- ISSUE:
  - aes_start=1 for one cycle; aes_block={nonce_q, cnt}.
  - last_blk=(remaining==1).
  - Go to WAIT.
- WAIT:
  - aes_done is sampled only in this state; pulses in other states are ignored.
  - On aes_done: cnt=cnt+1 (64-bit, wraps modulo 2^64); remaining=remaining-1.
  - If remaining becomes 0, go to FIN; else go to ISSUE.
  - Minimum block period is 2 cycles (ISSUE, then WAIT with aes_done on the first WAIT cycle).
- FIN:
  - done[owner]=1 for one cycle; gnt deasserts on the same edge.
  - rr pointer = owner+1 mod NREQ. Return to IDLE.
  - A fresh arbitration can grant at the earliest on the cycle after FIN.
- Arbitration boundaries:
  - Requests arriving while busy wait; there is no preemption.
  - The owner dropping req mid-session is ignored; the session runs to completion.
  - A non-owner dropping req before grant simply withdraws it.
  - req_len is sampled only at grant; later changes are ignored.
- Fairness: with all req bits held high, grants rotate 0,1,..,NREQ-1,0.
- Nonce: exactly one nonce_ready pulse per session with len>0, never more.
- Invariants:
  - aes_start is never asserted while a block is outstanding.
  - gnt is always one-hot or zero.
  - done is asserted only on the granted bit.

Test Plan:
1. Reset mid-session: assert reset=0 during WAIT → all outputs 0 immediately (async). After release, state=IDLE, rr=0, and no done pulse ever appears for the aborted session.
2. Single session: NREQ=2; req[0]=1, len=3; nonce stub=64'h0123456789ABCDEF; aes_done returned 2 cycles after each start.
   - Exactly one nonce_ready pulse, nonce sampled the cycle after.
   - aes_block = 128'h0123456789ABCDEF_0000000000000000, then ..._0000000000000001, then ..._0000000000000002.
   - last_blk set only on the third block; done[0] pulses once; gnt returns to 0.
3. Round-robin: req=2'b11 held, both len=1 → grants in order 0,1,0,1. done pulses alternate, and nonce_ready pulses once per session.
4. Zero length: req[1]=1, len=0 → gnt[1] high, then done[1] pulse. No nonce_ready, no aes_start; back to IDLE in at most 3 cycles after grant.
5. Counter wrap: CTR_INIT=64'hFFFF_FFFF_FFFF_FFFF, len=2 → counter fields FFFF…FFFF then 0000…0000; nonce field unchanged.
6. Spurious aes_done: pulse aes_done in IDLE and in NCAP, and req_len changes after grant → no state effect. Block counts follow the latched len.
